// File: rtl/md_unit_if.sv
// ---------------------------------------------------------------------------
// md_unit_if -- bundle of the E-stage multiply/divide signals.
//
// Signals:
//   md_op  [2:0]  operation code from the pipeline (0/7 none, 1 mult,
//                 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo)
//   flush         exception/interrupt request, suppresses this cycle's md_op
//   A, B   [31:0] rs / rt operands
//   start         combinational: a mult/div op is being issued this cycle
//   busy          registered: an operation is in progress
//   HI, LO [31:0] architectural HI/LO registers
//
// Modports:
//   master -- pipeline side (drives op/operands, reads status and HI/LO)
//   slave  -- md_unit side
// ---------------------------------------------------------------------------
interface md_unit_if;
    logic [2:0]  md_op;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output md_op, flush, A, B,
        input  start, busy, HI, LO
    );

    modport slave (
        input  md_op, flush, A, B,
        output start, busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers.
//
// An accepted mult/multu/div/divu latches its operands and keeps busy high
// for MULT_CYCLES or DIV_CYCLES cycles; HI/LO are written on the edge that
// ends the last busy cycle. mthi/mtlo write HI/LO directly when idle.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (default 5)
//   DIV_CYCLES   busy cycles for div/divu   (default 10)
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    md_unit_if.slave (md_op, flush, A, B in; start, busy, HI, LO out)
//
// Configuration macro:
//   MD_DIVZERO_KEEP_EN  when defined, a divide by zero leaves HI/LO
//                       unchanged; otherwise it writes LO=all ones, HI=A.
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   opA_q, opA_d;
    logic [31:0]   opB_q, opB_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          startReq;
    logic          busyInt;
    logic          accept;
    logic          complete;
    logic          mthiEn;
    logic          mtloEn;

    logic [63:0]   prodS;
    logic [63:0]   prodU;
    logic          divByZero;
    logic [31:0]   absA;
    logic [31:0]   absB;
    logic [31:0]   magQ;
    logic [31:0]   magR;
    logic [31:0]   sQuo;
    logic [31:0]   sRem;
    logic [31:0]   uQuo;
    logic [31:0]   uRem;

    // start is purely a decode of the incoming op; it does not look at busy
    // because the hazard unit already stalls around a running operation.
    assign startReq  = (bus.md_op inside {[OP_MULT:OP_DIVU]}) && !bus.flush;
    assign bus.start = startReq;
    assign bus.busy  = busyInt;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

    // State register: every flop in the unit, reset has priority over all
    // other updates so a reset mid-RUN discards the pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: accept only from IDLE, then count down once per RUN cycle.
    // The count is loaded with N and completion fires while it reads 1, which
    // gives exactly N busy cycles.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        if (accept) begin
            state_d = RUN;
            op_d    = bus.md_op;
            opA_d   = bus.A;
            opB_d   = bus.B;
            if ((bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU)) begin
                count_d = CW'(MULT_CYCLES);
            end else begin
                count_d = CW'(DIV_CYCLES);
            end
        end else if (state_q == RUN) begin
            count_d = count_q - CW'(1);
            if (complete) begin
                state_d = IDLE;
            end
        end
    end

    // Output/control decode from the current state. mthi/mtlo are only
    // honoured while idle so a stray one during RUN cannot corrupt HI/LO.
    always_comb begin
        busyInt  = (state_q == RUN);
        accept   = (state_q == IDLE) && startReq;
        complete = (state_q == RUN) && (count_q == CW'(1));
        mthiEn   = (state_q == IDLE) && !bus.flush && (bus.md_op == OP_MTHI);
        mtloEn   = (state_q == IDLE) && !bus.flush && (bus.md_op == OP_MTLO);
    end

    // Arithmetic on the latched operands. Signed division works on
    // magnitudes and fixes up the signs afterwards: the quotient is negative
    // when the operand signs differ, the remainder follows the dividend.
    // Doing it this way also avoids the overflow of -2^31 / -1.
    always_comb begin
        prodS     = {{32{opA_q[31]}}, opA_q} * {{32{opB_q[31]}}, opB_q};
        prodU     = {32'd0, opA_q} * {32'd0, opB_q};
        divByZero = (opB_q == 32'd0);
        absA      = opA_q[31] ? (~opA_q + 32'd1) : opA_q;
        absB      = opB_q[31] ? (~opB_q + 32'd1) : opB_q;
        magQ      = 32'd0;
        magR      = 32'd0;
        uQuo      = 32'd0;
        uRem      = 32'd0;
        if (!divByZero) begin
            magQ = absA / absB;
            magR = absA % absB;
            uQuo = opA_q / opB_q;
            uRem = opA_q % opB_q;
        end
        sQuo = (opA_q[31] ^ opB_q[31]) ? (~magQ + 32'd1) : magQ;
        sRem = opA_q[31] ? (~magR + 32'd1) : magR;
    end

    // HI/LO next value: completion of a running op, otherwise mthi/mtlo.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (complete) begin
            case (op_q)
                OP_MULT: begin
                    hi_d = prodS[63:32];
                    lo_d = prodS[31:0];
                end
                OP_MULTU: begin
                    hi_d = prodU[63:32];
                    lo_d = prodU[31:0];
                end
                OP_DIV, OP_DIVU: begin
                    if (divByZero) begin
`ifdef MD_DIVZERO_KEEP_EN
                        hi_d = hi_q;
                        lo_d = lo_q;
`else
                        hi_d = opA_q;
                        lo_d = 32'hFFFF_FFFF;
`endif
                    end else if (op_q == OP_DIV) begin
                        hi_d = sRem;
                        lo_d = sQuo;
                    end else begin
                        hi_d = uRem;
                        lo_d = uQuo;
                    end
                end
                default: begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            endcase
        end else begin
            if (mthiEn) begin
                hi_d = bus.A;
            end
            if (mtloEn) begin
                lo_d = bus.A;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit -- self-checking bench for md_unit.
//
// Inputs are driven 1 ns after the rising edge; results are observed on the
// falling edge. Every accepted mult/div pushes its expected HI/LO and busy
// length into expQ; the monitor pops an entry whenever busy falls.
// Build with +define+MD_DIVZERO_KEEP_EN to exercise the keep-on-zero variant.
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic reset;

    md_unit_if bus();

    md_unit #(
        .MULT_CYCLES(MULT_C),
        .DIV_CYCLES (DIV_C)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t        expQ[$];
    logic [31:0] modelHi;
    logic [31:0] modelLo;
    int          tests;
    int          fails;

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the run entirely.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single place where a comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the arithmetic definitions, using
    // 64-bit integers so signed division cannot overflow.
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] oldHi,
                                              input logic [31:0] oldLo);
        longint    sa;
        longint    sb;
        longint    q;
        longint    r;
        bit [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                q = sa * sb;
                return q;
            end
            3'd2: begin
                up = 64'(a) * 64'(b);
                return up;
            end
            default: begin
                if (b == 32'd0) begin
`ifdef MD_DIVZERO_KEEP_EN
                    return {oldHi, oldLo};
`else
                    return {a, 32'hFFFF_FFFF};
`endif
                end
                if (op == 3'd3) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(a) / longint'(b);
                    r = longint'(a) % longint'(b);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Drive one op for one cycle (DUT assumed idle), predict start, and
    // update the HI/LO model. Leaves the inputs idle one cycle later.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit fl, output bit accepted);
        logic [63:0] r;
        exp_t        e;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        bus.flush = fl;
        #1;
        accepted = (op >= 3'd1) && (op <= 3'd4) && !fl;
        checkOutput("start", 64'(bus.start), 64'(accepted));
        if (accepted) begin
            r        = refResult(op, a, b, modelHi, modelLo);
            modelHi  = r[63:32];
            modelLo  = r[31:0];
            e.hi     = modelHi;
            e.lo     = modelLo;
            e.cycles = (op <= 3'd2) ? MULT_C : DIV_C;
            expQ.push_back(e);
        end else if (!fl && op == 3'd5) begin
            modelHi = a;
        end else if (!fl && op == 3'd6) begin
            modelLo = a;
        end
        @(posedge clk);
        #1;
        bus.md_op = 3'd0;
        bus.flush = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Step until busy drops, bounded; leaves us in the first idle cycle.
    task automatic waitIdle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("busy_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_HI"}, 64'(bus.HI), 64'(modelHi));
        checkOutput({tag, "_LO"}, 64'(bus.LO), 64'(modelLo));
    endtask

    // Monitor: count busy cycles and compare HI/LO against the oldest
    // expectation on every busy falling edge.
    initial begin : monitor
        int   busyRun;
        logic prevBusy;
        exp_t e;
        busyRun  = 0;
        prevBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busyRun  = 0;
                prevBusy = 1'b0;
            end else begin
                if (bus.busy) begin
                    busyRun++;
                end else if (prevBusy) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_completion", 64'd1, 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("result_HI", 64'(bus.HI), 64'(e.hi));
                        checkOutput("result_LO", 64'(bus.LO), 64'(e.lo));
                        checkOutput("busy_len", 64'(busyRun), 64'(e.cycles));
                    end
                    busyRun = 0;
                end
                prevBusy = bus.busy;
            end
        end
    end

    // Directed corner cases first, then a randomized sequence.
    initial begin : stimulus
        bit acc;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          fl;

        tests     = 0;
        fails     = 0;
        modelHi   = 32'd0;
        modelLo   = 32'd0;
        reset     = 1'b1;
        bus.md_op = 3'd0;
        bus.flush = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkRegs("reset");
        checkOutput("reset_start", 64'(bus.start), 64'd0);

        // mult / multu with a negative operand.
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, acc);
        waitIdle();
        checkRegs("mult");
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, acc);
        waitIdle();
        checkRegs("multu");

        // div with negative dividend, divu small values.
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, acc);
        waitIdle();
        checkRegs("div");
        applyStimulus(3'd4, 32'd7, 32'd2, 1'b0, acc);
        waitIdle();
        checkRegs("divu");

        // mthi, flushed mtlo, flushed mult.
        applyStimulus(3'd5, 32'h1234, 32'd0, 1'b0, acc);
        checkRegs("mthi");
        applyStimulus(3'd6, 32'h5678, 32'd0, 1'b1, acc);
        checkRegs("mtlo_flush");
        applyStimulus(3'd1, 32'd3, 32'd3, 1'b1, acc);
        checkOutput("flush_busy", 64'(bus.busy), 64'd0);

        // Reset on the second busy cycle discards the result.
        applyStimulus(3'd1, 32'd3, 32'd4, 1'b0, acc);
        @(posedge clk);
        #1;
        reset = 1'b1;
        expQ.delete();
        modelHi = 32'd0;
        modelLo = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midrun_reset_busy", 64'(bus.busy), 64'd0);
        checkRegs("midrun_reset");
        repeat (8) @(posedge clk);
        #1;
        checkRegs("after_reset");

        // divu issued on busy cycle 3 of a mult must be ignored.
        applyStimulus(3'd1, 32'd2, 32'd3, 1'b0, acc);
        repeat (2) @(posedge clk);
        #1;
        bus.md_op = 3'd4;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        #1;
        checkOutput("busy_start", 64'(bus.start), 64'd1);
        checkOutput("busy_mid", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        bus.md_op = 3'd5;
        bus.A     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.md_op = 3'd0;
        waitIdle();
        checkRegs("ignored_op");

        // Divide by zero with preset HI/LO.
        applyStimulus(3'd5, 32'h11, 32'd0, 1'b0, acc);
        applyStimulus(3'd6, 32'h22, 32'd0, 1'b0, acc);
        applyStimulus(3'd3, 32'd5, 32'd0, 1'b0, acc);
        waitIdle();
        checkRegs("divzero");

        // Random mix; a new op always lands in the first idle cycle.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
            end
            fl = ($urandom_range(0, 7) == 0);
            applyStimulus(op, a, b, fl, acc);
            if (acc) begin
                waitIdle();
            end
            checkRegs("random");
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port md_op  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
REQ-006 SHALL have port flush  input  1  exception/interrupt request; when high, suppresses this cycle's md_op.
REQ-007 SHALL have port A  input  32  rs operand.
REQ-008 SHALL have port B  input  32  rt operand.
REQ-009 SHALL have port start  output  1  combinational: md_op in 1..4 and !flush.
REQ-010 SHALL have port busy  output  1  registered: operation in progress.
REQ-011 SHALL have port HI  output  32  registered HI register, read directly by mfhi.
REQ-012 SHALL have port LO  output  32  registered LO register, read directly by mflo.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN, plus a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-014 Accept: in IDLE with start=1 -> latch A, B and op; load counter with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4); go to RUN.
REQ-015 busy SHALL be 1 for exactly N consecutive cycles, starting the cycle after the accept edge (N = loaded count).
REQ-016 HI/LO SHALL update on the edge that ends the last busy cycle; new values SHALL be visible in the first cycle with busy=0; FSM then returns to IDLE.
REQ-017 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-018 div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend; divu: unsigned quotient and remainder.
REQ-019 Results SHALL use latched operands only; A/B changes during RUN SHALL have no effect.
REQ-020 mthi (md_op=5) with !flush and !busy SHALL write HI=A at the next edge; mtlo (6) SHALL write LO=A the same way; the other register is unchanged.
REQ-021 Any md_op 1..6 arriving while busy=1 SHALL be ignored; the hazard unit guarantees this does not occur, but RTL SHALL be safe.
REQ-022 flush=1 SHALL suppress accept and mthi/mtlo in that cycle; flush SHALL NOT abort an operation already in RUN.
REQ-023 md_op 0 or 7 SHALL cause no state change.
REQ-024 Back-to-back: a new start in the first cycle with busy=0 SHALL be accepted; the result is visible to mfhi/mflo in that same cycle.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, counter=0, busy=0, HI=0, LO=0, and clear latched operands.
REQ-026 reset SHALL take priority over start, mthi/mtlo and completion in the same cycle; reset mid-RUN discards the result.

Configuration
REQ-027 Macro MD_DIVZERO_KEEP_EN: when defined, div/divu with latched B=0 SHALL run the full DIV_CYCLES and leave HI/LO unchanged.
REQ-028 When MD_DIVZERO_KEEP_EN is undefined, div/divu with B=0 SHALL write LO=32'hFFFFFFFF and HI=latched A after DIV_CYCLES.

Verification
REQ-029 mult A=0xFFFFFFFF, B=2 -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 div A=0xFFFFFFF9, B=2 -> busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-031 mthi A=0x1234 with flush=0 -> HI=0x1234 next cycle; mtlo A=0x5678 with flush=1 -> LO unchanged; mult with flush=1 -> start=0, busy stays 0.
REQ-032 mult A=3, B=4 accepted, reset=1 on 2nd busy cycle -> next cycle busy=0, HI=0, LO=0; no later update.
REQ-033 mult A=2, B=3 in RUN, md_op=4 with A=9, B=9 on busy cycle 3 -> ignored; LO=6, HI=0; busy falls after 5 cycles total.
REQ-034 div A=5, B=0 with HI=0x11, LO=0x22 preset -> with macro HI=0x11, LO=0x22; without macro HI=5, LO=0xFFFFFFFF.
